sim_harness_ctrl: RTL and testbench
===================================

# sim_harness_ctrl

Parametrised test-harness controller for multi-hart RV32I simulation. Generates the core-side reset release after a programmable hold, and runs a saturating cycle counter with a watchdog timeout. It monitors each hart's data-store port for writes to the `tohost` address and reports pass/fail/timeout as sticky registered status. It sits between the bench clock/reset source and one or more `rv32i_core` instances, replacing fixed-delay reset and `#delay $finish` sequencing with cycle-accurate, checkable end-of-test detection.

## Interface
Parameters:
- `N_HARTS`, 1: number of monitored hart store ports.
- `RST_HOLD_CYCLES`, 2: cycles `core_rst` stays high after `rst` deasserts. Range 1–255.
- `TIMEOUT_CYCLES`, 2000: RUN-state watchdog limit. 0 disables the timeout.
- `TOHOST_ADDR`, 32'h0000_1000: magic store address.
- `CNT_W`, 32: cycle counter width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `st_we` in N_HARTS: per-hart store strobe, one cycle per store.
- `st_addr` in 32*N_HARTS: per-hart store address. Hart h occupies bits [32h+31:32h].
- `st_wdata` in 32*N_HARTS: per-hart store data, same packing.
- `core_rst` out 1: active-high reset to cores.
- `running` out 1: high in RUN.
- `done` out 1: sticky; test finished by any cause.
- `pass` out 1: sticky; all harts passed.
- `fail` out 1: sticky; a hart reported failure.
- `timeout` out 1: sticky; watchdog expired.
- `fail_hart` out $clog2(N_HARTS) (min 1): index of the failing hart.
- `fail_code` out 31: `st_wdata[31:1]` of the failing write.
- `hart_passed` out N_HARTS: per-hart pass bits.
- `cycle_count` out CNT_W: RUN cycles elapsed.

## Operation
- FSM states: HOLD, RUN, PASS, FAIL, TIMEOUT.
- `rst` low, asynchronously: state=HOLD, `core_rst`=1, hold counter=0, and every other output=0.
- HOLD:
  - Hold counter increments each edge.
  - When it reaches RST_HOLD_CYCLES-1, next state=RUN, `core_rst`=0, `running`=1, `cycle_count`=0.
- RUN, per hart h, when `st_we[h]` is high and `st_addr`=TOHOST_ADDR:
  - wdata==1: pass event for h. Sets `hart_passed[h]`.
  - wdata[0]==1 and wdata!=1: fail event for h.
  - wdata==0 or wdata[0]==0: ignored.
  - Stores to any other address are ignored.
  - Stores from a hart whose `hart_passed` bit is already set are ignored.
- `cycle_count`: increments each RUN edge and saturates at all-ones. It freezes on leaving RUN.
- RUN exit, priority FAIL > PASS > TIMEOUT, evaluated on the same edge:
  - Any fail event goes to FAIL. `fail_hart` = lowest-index failing hart; `fail_code` = that hart's wdata[31:1].
  - Else, if all `hart_passed` bits (including this edge's events) are set, go to PASS.
  - Else, if TIMEOUT_CYCLES≠0 and `cycle_count`==TIMEOUT_CYCLES-1, go to TIMEOUT.
- PASS, FAIL, TIMEOUT:
  - Terminal until `rst` goes low.
  - `done`=1, `running`=0, `core_rst` stays 0 so the wave state is preserved.
  - All store inputs are ignored.
- Only one of `pass`/`fail`/`timeout` is ever high.
- Store inputs are ignored in HOLD.

## Timing
- All outputs are flop outputs, updated on the sampling rising edge. There are no combinational input→output paths.
- Reset release:
  - `rst` deassertion must be synchronous to `clk` at the bench.
  - `core_rst` falls on the RST_HOLD_CYCLES-th rising edge after `rst` rises.
- A qualifying store sampled at edge N produces `done`/`pass`/`fail`/`hart_passed` visible after edge N.
- `cycle_count` reads k after the k-th RUN edge. With TIMEOUT_CYCLES=T, `timeout` rises on the T-th RUN edge, when `cycle_count`=T.
- `rst` asserted mid-RUN or in a terminal state: immediate asynchronous return to reset values, and the full HOLD sequence reruns.
- Simultaneous events:
  - Pass and fail events from different harts on the same edge resolve to FAIL. `hart_passed` for the passing harts is still set.
  - A completing event on the timeout edge wins over timeout.

## Test plan
- N_HARTS=1, RST_HOLD_CYCLES=2. Release `rst` at edge 0 → `core_rst` falls after edge 2 and `running`=1. Hart 0 stores 1 to 0x1000 at RUN cycle 10 → `pass`=`done`=1, `cycle_count`=11, and stays so for 50 more cycles.
- Hart 0 stores 0x0000_0007 to 0x1000 → `fail`=1, `fail_code`=3, `fail_hart`=0. A store of 0x0000_0002 to 0x1000 and a store of 1 to 0x1004 beforehand cause no change.
- TIMEOUT_CYCLES=20, no stores → `timeout`=1 exactly when `cycle_count`=20. Rerun with a pass on cycle 19 → `pass`=1, `timeout`=0.
- N_HARTS=2:
  - Hart 1 passes at cycle 5 → `hart_passed`=2'b10, `done`=0.
  - Hart 1 then stores 3 → ignored.
  - Hart 0 passes at cycle 8 → `pass`=1.
  - Second run: hart 0 stores 1 and hart 1 stores 5 on the same edge → `fail`=1, `fail_hart`=1, `fail_code`=2, `hart_passed`=2'b01.
- Assert `rst` low mid-RUN at cycle 30 → all outputs return to reset values asynchronously (`core_rst`=1, `cycle_count`=0). On release, HOLD repeats for RST_HOLD_CYCLES.
- TIMEOUT_CYCLES=0, CNT_W=4, no stores → `cycle_count` saturates at 15 and `done` stays 0.

Source files
------------

// File: rtl/sim_harness_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sim_harness_ctrl
//  Purpose  : Multi-hart RV32I test-harness controller: core reset sequencing,
//             RUN cycle counter with watchdog, tohost pass/fail detection.
//  Revision : 1.0
// ============================================================================

module sim_harness_ctrl #(
    parameter int          N_HARTS         = 1,
    parameter int          RST_HOLD_CYCLES = 2,
    parameter int          TIMEOUT_CYCLES  = 2000,
    parameter logic [31:0] TOHOST_ADDR     = 32'h0000_1000,
    parameter int          CNT_W           = 32,
    localparam int         FH_W            = (N_HARTS > 1) ? $clog2(N_HARTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_HARTS-1:0]     st_we,
    input  logic [32*N_HARTS-1:0]  st_addr,
    input  logic [32*N_HARTS-1:0]  st_wdata,
    output logic                   core_rst,
    output logic                   running,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout,
    output logic [FH_W-1:0]        fail_hart,
    output logic [30:0]            fail_code,
    output logic [N_HARTS-1:0]     hart_passed,
    output logic [CNT_W-1:0]       cycle_count
);

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    localparam logic [7:0]       c_hold_last    = 8'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_max      = '1;
    localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_hold_cnt, w_hold_nxt;
    logic               r_core_rst, w_core_rst_nxt;
    logic               r_running, w_running_nxt;
    logic               r_done, w_done_nxt;
    logic               r_pass, w_pass_nxt;
    logic               r_fail, w_fail_nxt;
    logic               r_timeout, w_timeout_nxt;
    logic [FH_W-1:0]    r_fail_hart, w_fail_hart_nxt;
    logic [30:0]        r_fail_code, w_fail_code_nxt;
    logic [N_HARTS-1:0] r_hart_passed, w_hart_passed_nxt;
    logic [CNT_W-1:0]   r_cycle_count, w_cycle_count_nxt;

    logic [N_HARTS-1:0] w_pass_ev, w_fail_ev, w_passed_all;
    logic [FH_W-1:0]    w_fh;
    logic [30:0]        w_fcode;

    // Harts that already passed are masked out so late stores cannot flip the verdict.
    for (genvar h = 0; h < N_HARTS; h++) begin : g_hart
        logic [31:0] w_addr;
        logic [31:0] w_data;
        logic        w_hit;
        assign w_addr       = st_addr[32*h +: 32];
        assign w_data       = st_wdata[32*h +: 32];
        assign w_hit        = st_we[h] && (w_addr == TOHOST_ADDR) && !r_hart_passed[h];
        assign w_pass_ev[h] = w_hit && (w_data == 32'd1);
        assign w_fail_ev[h] = w_hit && w_data[0] && (w_data != 32'd1);
    end

    assign w_passed_all = r_hart_passed | w_pass_ev;

    // Descending scan so the lowest-index failing hart is the one reported.
    always_comb begin
        w_fh    = '0;
        w_fcode = '0;
        for (int h = N_HARTS - 1; h >= 0; h--) begin
            if (w_fail_ev[h]) begin
                w_fh    = FH_W'(h);
                w_fcode = st_wdata[32*h + 1 +: 31];
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_hold_nxt        = r_hold_cnt;
        w_core_rst_nxt    = r_core_rst;
        w_running_nxt     = r_running;
        w_done_nxt        = r_done;
        w_pass_nxt        = r_pass;
        w_fail_nxt        = r_fail;
        w_timeout_nxt     = r_timeout;
        w_fail_hart_nxt   = r_fail_hart;
        w_fail_code_nxt   = r_fail_code;
        w_hart_passed_nxt = r_hart_passed;
        w_cycle_count_nxt = r_cycle_count;
        case (r_state)
            S_HOLD: begin
                w_hold_nxt = r_hold_cnt + 8'd1;
                if (r_hold_cnt == c_hold_last) begin
                    w_state_nxt       = S_RUN;
                    w_core_rst_nxt    = 1'b0;
                    w_running_nxt     = 1'b1;
                    w_cycle_count_nxt = '0;
                end
            end
            S_RUN: begin
                w_cycle_count_nxt = (r_cycle_count == c_cnt_max) ? r_cycle_count
                                                                 : r_cycle_count + c_cnt_one;
                w_hart_passed_nxt = w_passed_all;
                if (|w_fail_ev) begin
                    w_state_nxt     = S_FAIL;
                    w_fail_nxt      = 1'b1;
                    w_done_nxt      = 1'b1;
                    w_running_nxt   = 1'b0;
                    w_fail_hart_nxt = w_fh;
                    w_fail_code_nxt = w_fcode;
                end else if (&w_passed_all) begin
                    w_state_nxt   = S_PASS;
                    w_pass_nxt    = 1'b1;
                    w_done_nxt    = 1'b1;
                    w_running_nxt = 1'b0;
                end else if ((TIMEOUT_CYCLES != 0) && (r_cycle_count == c_timeout_last)) begin
                    w_state_nxt   = S_TIMEOUT;
                    w_timeout_nxt = 1'b1;
                    w_done_nxt    = 1'b1;
                    w_running_nxt = 1'b0;
                end
            end
            default: begin
                // Terminal states hold everything until rst.
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_HOLD;
            r_hold_cnt    <= '0;
            r_core_rst    <= 1'b1;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
            r_fail_hart   <= '0;
            r_fail_code   <= '0;
            r_hart_passed <= '0;
            r_cycle_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_core_rst    <= w_core_rst_nxt;
            r_running     <= w_running_nxt;
            r_done        <= w_done_nxt;
            r_pass        <= w_pass_nxt;
            r_fail        <= w_fail_nxt;
            r_timeout     <= w_timeout_nxt;
            r_fail_hart   <= w_fail_hart_nxt;
            r_fail_code   <= w_fail_code_nxt;
            r_hart_passed <= w_hart_passed_nxt;
            r_cycle_count <= w_cycle_count_nxt;
        end
    end

    assign core_rst    = r_core_rst;
    assign running     = r_running;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign fail_hart   = r_fail_hart;
    assign fail_code   = r_fail_code;
    assign hart_passed = r_hart_passed;
    assign cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_sim_harness_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sim_harness_ctrl
//  Purpose  : Self-checking bench: randomized tohost stores vs. outcome model.
//  Revision : 1.0
// ============================================================================

module tb_sim_harness_ctrl;

    localparam logic [31:0] c_tohost  = 32'h0000_1000;
    localparam int          c_a_hold  = 2;
    localparam int          c_a_to    = 20;
    localparam int          c_b_hold  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 2 harts, watchdog 20
    logic        rst_a = 1'b0;
    logic [1:0]  st_we_a = '0;
    logic [63:0] st_addr_a = '0, st_wdata_a = '0;
    logic        core_rst_a, running_a, done_a, pass_a, fail_a, timeout_a;
    logic [0:0]  fail_hart_a;
    logic [30:0] fail_code_a;
    logic [1:0]  hart_passed_a;
    logic [31:0] cycle_count_a;

    // DUT B: 1 hart, no watchdog, 4-bit counter
    logic        rst_b = 1'b0;
    logic [0:0]  st_we_b = '0;
    logic [31:0] st_addr_b = '0, st_wdata_b = '0;
    logic        core_rst_b, running_b, done_b, pass_b, fail_b, timeout_b;
    logic [0:0]  fail_hart_b;
    logic [30:0] fail_code_b;
    logic [0:0]  hart_passed_b;
    logic [3:0]  cycle_count_b;

    sim_harness_ctrl #(.N_HARTS(2), .RST_HOLD_CYCLES(c_a_hold), .TIMEOUT_CYCLES(c_a_to),
                       .TOHOST_ADDR(c_tohost), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst(rst_a), .st_we(st_we_a), .st_addr(st_addr_a), .st_wdata(st_wdata_a),
        .core_rst(core_rst_a), .running(running_a), .done(done_a), .pass(pass_a),
        .fail(fail_a), .timeout(timeout_a), .fail_hart(fail_hart_a), .fail_code(fail_code_a),
        .hart_passed(hart_passed_a), .cycle_count(cycle_count_a)
    );

    sim_harness_ctrl #(.N_HARTS(1), .RST_HOLD_CYCLES(c_b_hold), .TIMEOUT_CYCLES(0),
                       .TOHOST_ADDR(c_tohost), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst_b), .st_we(st_we_b), .st_addr(st_addr_b), .st_wdata(st_wdata_b),
        .core_rst(core_rst_b), .running(running_b), .done(done_b), .pass(pass_b),
        .fail(fail_b), .timeout(timeout_b), .fail_hart(fail_hart_b), .fail_code(fail_code_b),
        .hart_passed(hart_passed_b), .cycle_count(cycle_count_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // {core_rst, running, done, pass, fail, timeout}
    function automatic logic [5:0] stat_a();
        return {core_rst_a, running_a, done_a, pass_a, fail_a, timeout_a};
    endfunction
    function automatic logic [5:0] stat_b();
        return {core_rst_b, running_b, done_b, pass_b, fail_b, timeout_b};
    endfunction

    // Store schedule for DUT A, indexed by RUN cycle and hart
    logic        s_we   [c_a_to][2];
    logic [31:0] s_addr [c_a_to][2];
    logic [31:0] s_data [c_a_to][2];

    // Expected outcome
    int          exp_end, exp_res;   // res: 1 pass, 2 fail, 3 timeout
    logic [0:0]  exp_fh;
    logic [30:0] exp_code;
    logic [1:0]  exp_passed [c_a_to];

    task automatic clear_sched();
        for (int c = 0; c < c_a_to; c++)
            for (int h = 0; h < 2; h++) begin
                s_we[c][h] = 1'b0; s_addr[c][h] = '0; s_data[c][h] = '0;
            end
    endtask

    task automatic put(input int c, input int h, input logic [31:0] a, input logic [31:0] d);
        s_we[c][h] = 1'b1; s_addr[c][h] = a; s_data[c][h] = d;
    endtask

    function automatic logic [31:0] rand_data();
        int r;
        r = $urandom_range(0, 9);
        if (r < 5)       return 32'd1;
        else if (r < 7)  return $urandom & 32'hFFFF_FFFE;
        else if (r == 7) return 32'd0;
        else             return $urandom | 32'd1;
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      return c_tohost + 32'd4;
        else if (r == 1) return $urandom;
        else             return c_tohost;
    endfunction

    task automatic rand_sched();
        for (int c = 0; c < c_a_to; c++)
            for (int h = 0; h < 2; h++) begin
                s_we[c][h]   = ($urandom_range(0, 99) < 15);
                s_addr[c][h] = rand_addr();
                s_data[c][h] = rand_data();
            end
    endtask

    // Walk the schedule applying the tohost rules; first verdict wins.
    task automatic model_a();
        logic [1:0] got_pass;
        int         ff;
        got_pass = 2'b00;
        exp_res  = 3; exp_end = c_a_to - 1; exp_fh = '0; exp_code = '0;
        for (int c = 0; c < c_a_to; c++) begin
            ff = -1;
            for (int h = 0; h < 2; h++) begin
                if (s_we[c][h] && s_addr[c][h] == c_tohost && !got_pass[h]) begin
                    if (s_data[c][h] == 32'd1)            got_pass[h] = 1'b1;
                    else if (s_data[c][h][0] && ff < 0)   ff = h;
                end
            end
            exp_passed[c] = got_pass;
            if (ff >= 0) begin
                exp_res = 2; exp_end = c; exp_fh = 1'(ff); exp_code = s_data[c][ff][31:1];
                return;
            end
            if (got_pass == 2'b11) begin
                exp_res = 1; exp_end = c;
                return;
            end
        end
    endtask

    task automatic check_final_a();
        check("a_end_stat", stat_a(), {3'b001, exp_res == 1, exp_res == 2, exp_res == 3});
        check("a_end_cnt", cycle_count_a, exp_end + 1);
        check("a_end_passed", hart_passed_a, exp_passed[exp_end]);
        check("a_end_failinfo", {fail_hart_a, fail_code_a},
              (exp_res == 2) ? {exp_fh, exp_code} : 32'd0);
    endtask

    task automatic run_a();
        model_a();
        rst_a = 1'b0; st_we_a = '0; st_addr_a = '0; st_wdata_a = '0;
        #1;
        check("a_rst_stat", stat_a(), 6'b100000);
        check("a_rst_cnt", cycle_count_a, 0);
        check("a_rst_misc", {hart_passed_a, fail_hart_a, fail_code_a}, 0);
        @(posedge clk); #1; rst_a = 1'b1;
        for (int i = 1; i < c_a_hold; i++) begin
            @(posedge clk); #1;
            check("a_hold_stat", stat_a(), 6'b100000);
        end
        @(posedge clk); #1;
        check("a_release_stat", stat_a(), 6'b010000);
        check("a_release_cnt", cycle_count_a, 0);
        for (int c = 0; c <= exp_end; c++) begin
            for (int h = 0; h < 2; h++) begin
                st_we_a[h] = s_we[c][h];
                st_addr_a[32*h +: 32] = s_addr[c][h];
                st_wdata_a[32*h +: 32] = s_data[c][h];
            end
            @(posedge clk); #1;
            if (c < exp_end) begin
                check("a_run_stat", stat_a(), 6'b010000);
                check("a_run_cnt", cycle_count_a, c + 1);
                check("a_run_passed", hart_passed_a, exp_passed[c]);
            end else begin
                check_final_a();
            end
        end
        for (int k = 0; k < 6; k++) begin
            st_we_a = 2'($urandom);
            st_addr_a = {c_tohost, c_tohost};
            st_wdata_a = {rand_data(), rand_data()};
            @(posedge clk); #1;
            check_final_a();
        end
        st_we_a = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=no_finish expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        @(posedge clk); #1;

        // DUT A directed cases
        clear_sched(); run_a();                                   // watchdog expiry
        clear_sched(); put(3, 0, c_tohost, 1); put(19, 1, c_tohost, 1); run_a();
        clear_sched(); put(5, 1, c_tohost, 1); put(6, 1, c_tohost, 3);
        put(8, 0, c_tohost, 1); run_a();
        clear_sched(); put(4, 0, c_tohost, 1); put(4, 1, c_tohost, 5); run_a();
        clear_sched(); put(2, 0, c_tohost, 2); put(3, 0, c_tohost + 32'd4, 1);
        put(6, 0, c_tohost, 7); run_a();
        // DUT A random runs
        for (int n = 0; n < 30; n++) begin
            rand_sched(); run_a();
        end

        // DUT B: reset, HOLD with a fail-valued store that must be ignored
        check("b_rst_stat", stat_b(), 6'b100000);
        check("b_rst_cnt", cycle_count_b, 0);
        @(posedge clk); #1;
        rst_b = 1'b1; st_we_b = 1'b1; st_addr_b = c_tohost; st_wdata_b = 32'd7;
        for (int i = 1; i < c_b_hold; i++) begin
            @(posedge clk); #1;
            check("b_hold_stat", stat_b(), 6'b100000);
        end
        @(posedge clk); #1;
        check("b_release_stat", stat_b(), 6'b010000);
        check("b_release_cnt", cycle_count_b, 0);
        // Non-qualifying stores only; counter must saturate at 15
        for (int c = 0; c < 30; c++) begin
            st_we_b = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                st_addr_b = c_tohost + 32'd4; st_wdata_b = $urandom;
            end else begin
                st_addr_b = c_tohost; st_wdata_b = $urandom & 32'hFFFF_FFFE;
            end
            @(posedge clk); #1;
            check("b_run_stat", stat_b(), 6'b010000);
            check("b_sat_cnt", cycle_count_b, (c + 1 > 15) ? 15 : c + 1);
            check("b_run_passed", hart_passed_b, 0);
        end
        // Asynchronous reset mid-RUN
        #3; rst_b = 1'b0; st_we_b = 1'b0;
        #1;
        check("b_async_stat", stat_b(), 6'b100000);
        check("b_async_cnt", cycle_count_b, 0);
        @(posedge clk); #1; rst_b = 1'b1;
        for (int i = 1; i < c_b_hold; i++) begin
            @(posedge clk); #1;
            check("b_rehold_stat", stat_b(), 6'b100000);
        end
        @(posedge clk); #1;
        check("b_rerelease_stat", stat_b(), 6'b010000);
        for (int c = 0; c <= 5; c++) begin
            st_we_b = (c == 5); st_addr_b = c_tohost; st_wdata_b = 32'd1;
            @(posedge clk); #1;
        end
        check("b_pass_stat", stat_b(), 6'b001100);
        check("b_pass_cnt", cycle_count_b, 6);
        check("b_pass_bits", hart_passed_b, 1);
        for (int k = 0; k < 50; k++) begin
            st_we_b = 1'b1; st_addr_b = c_tohost; st_wdata_b = $urandom | 32'd1;
            @(posedge clk); #1;
            check("b_hold_pass_stat", stat_b(), 6'b001100);
            check("b_hold_pass_cnt", {cycle_count_b, fail_code_b}, {4'd6, 31'd0});
        end
        st_we_b = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
